// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl: four-digit multiplexed 7-segment scan controller.
// Rotates the active-low anodes and feeds each digit's BCD nibble to an
// external decoder. Each slot starts with a dead-time gap. Digits can be
// disabled individually or blanked as leading zeros. New values are double
// buffered and only become visible at a frame boundary.
// Optional macro SEVSEG_BLINK_EN adds blink_mask and a blink phase counter.
module seven_seg_scan_ctrl #(
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYCLES = 4,
  parameter int BLINK_DIV   = 50000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] load_data,
  input  logic [3:0]  digit_en,
  input  logic        lz_en,
  output logic [3:0]  digit_code,
  output logic [3:0]  an,
  output logic [1:0]  digit_idx,
  output logic        frame_tick
`ifdef SEVSEG_BLINK_EN
  ,
  input  logic [3:0]  blink_mask
`endif
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_DEAD = CW'(DEAD_CYCLES);

  if (REFRESH_DIV < 4 || DEAD_CYCLES >= REFRESH_DIV || BLINK_DIV < 1) begin : g_param_check
    $error("seven_seg_scan_ctrl: illegal REFRESH_DIV/DEAD_CYCLES/BLINK_DIV");
  end

  typedef enum logic {ST_DEAD, ST_SCAN} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    idx_n;
  logic [15:0]   active, active_n;
  logic [15:0]   pend, pend_n;
  logic          pend_full, pend_full_n;
  logic [3:0]    an_n;
  logic [3:0]    code_n;
  logic          last_slot, wrap, accept;
  logic [3:0]    nib_n;
  logic          lz_blank, blink_blank, blank;

  assign load_ready = ~pend_full;

`ifdef SEVSEG_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [BW-1:0] blink_cnt;
  logic          blink_hide;
  logic          blink_hide_n;

  assign blink_hide_n = (blink_cnt == BLINK_LAST) ? ~blink_hide : blink_hide;
  // Blanking looks at the phase that will hold during the next cycle, so it
  // lines up with the registered anode value.
  assign blink_blank  = blink_hide_n & blink_mask[idx_n];

  // Free-running blink phase: visible half first, then hidden half.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt  <= '0;
      blink_hide <= 1'b0;
    end else begin
      blink_cnt  <= (blink_cnt == BLINK_LAST) ? '0 : blink_cnt + BW'(1);
      blink_hide <= blink_hide_n;
    end
  end
`else
  assign blink_blank = 1'b0;
`endif

  // Next-state: slot timing, buffer handoff, blanking and registered outputs.
  // Outputs are computed from next-cycle values so they align with the counter.
  always_comb begin
    last_slot   = (cnt == CNT_LAST);
    wrap        = last_slot && (digit_idx == 2'd3);
    cnt_n       = last_slot ? '0 : cnt + CW'(1);
    idx_n       = last_slot ? digit_idx + 2'd1 : digit_idx;
    accept      = load_valid && load_ready;

    active_n    = active;
    pend_n      = pend;
    pend_full_n = pend_full;
    // A load coinciding with the frame wrap skips the pending buffer.
    if (wrap && accept) begin
      active_n = load_data;
    end else if (wrap && pend_full) begin
      active_n    = pend;
      pend_full_n = 1'b0;
    end else if (accept) begin
      pend_n      = load_data;
      pend_full_n = 1'b1;
    end

    nib_n = active_n[{idx_n, 2'b00} +: 4];

    lz_blank = 1'b0;
    if (lz_en) begin
      case (idx_n)
        2'd1:    lz_blank = (active_n[15:4]  == '0);
        2'd2:    lz_blank = (active_n[15:8]  == '0);
        2'd3:    lz_blank = (active_n[15:12] == '0);
        default: lz_blank = 1'b0;
      endcase
    end
    blank = ~digit_en[idx_n] | lz_blank | blink_blank;

    state_n = state;
    case (state)
      ST_DEAD: if (cnt_n >= CNT_DEAD) state_n = ST_SCAN;
      ST_SCAN: if (last_slot && CNT_DEAD != '0) state_n = ST_DEAD;
      default: state_n = ST_DEAD;
    endcase

    an_n = '1;
    if (state_n == ST_SCAN && !blank) an_n[idx_n] = 1'b0;

    code_n = (cnt_n == '0) ? nib_n : digit_code;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_DEAD;
      cnt        <= '0;
      digit_idx  <= '0;
      active     <= '0;
      pend       <= '0;
      pend_full  <= 1'b0;
      an         <= '1;
      digit_code <= '0;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      digit_idx  <= idx_n;
      active     <= active_n;
      pend       <= pend_n;
      pend_full  <= pend_full_n;
      an         <= an_n;
      digit_code <= code_n;
      frame_tick <= wrap;
    end
  end

endmodule

// File: doc/seven_seg_scan_ctrl.md
Name: seven_seg_scan_ctrl

Overview:
Time-multiplexes the single-digit BCD-to-segment decoder across the four digits of the board display. Holds a double-buffered 16-bit value (four BCD nibbles) and rotates the active anode at a fixed refresh rate. Applies a dead-time gap between digits to avoid ghosting, plus per-digit enable and leading-zero blanking. Its digit_code drives the decoder's 4-bit input; its an drives the board anodes directly.

Parameters:
REFRESH_DIV, 100000, clock cycles per digit slot (min 4; 100 MHz -> 1 kHz slot rate)
DEAD_CYCLES, 4, cycles at slot start with all anodes off (must be < REFRESH_DIV)
BLINK_DIV, 50000000, half-period of blink in clock cycles (used only with SEVSEG_BLINK_EN)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
load_valid  input  1  new display value offered
load_ready  output  1  pending buffer empty; value can be accepted
load_data  input  16  four BCD nibbles; [3:0]=digit0 (rightmost) ... [15:12]=digit3
digit_en  input  4  per-digit enable, sampled live; 0 = digit dark
lz_en  input  1  leading-zero suppression enable, sampled live
digit_code  output  4  nibble for current slot, to decoder input
an  output  4  anodes, active-low, at most one bit low
digit_idx  output  2  current slot index
frame_tick  output  1  one-cycle pulse on each 3->0 slot wrap
blink_mask  input  4  per-digit blink select (present only with SEVSEG_BLINK_EN)

Behaviour:
- Reset: active=16'h0000, pending empty, load_ready=1, digit_idx=0, slot counter=0, an=4'b1111, digit_code=4'h0, frame_tick=0.
- Slot counter counts 0..REFRESH_DIV-1. At REFRESH_DIV-1: counter->0, digit_idx increments mod 4.
- Two states per slot: DEAD (counter < DEAD_CYCLES) drives an=4'b1111; SCAN (counter >= DEAD_CYCLES) drives an[digit_idx]=0, others 1, unless the digit is blanked.
- digit_code = active nibble for digit_idx, registered; updates on the first DEAD cycle of the slot and is stable for the whole slot. Nibbles >9 pass through unmodified.
- Blanked digit (an stays 4'b1111 for the whole slot): digit_en[idx]=0, or lz_en=1 and idx>=1 and the nibble at idx and every higher nibble are zero. Digit 0 is never blanked by lz. All anodes off is legal.
- Handshake: accept when load_valid & load_ready. The accepted value goes to pending; load_ready drops the next cycle.
- Frame boundary = the cycle digit_idx wraps 3->0. frame_tick=1 that cycle. If pending is full, pending->active and pending empties; load_ready=1 the next cycle.
- An accept on the frame-boundary cycle bypasses pending: load_data goes straight to active, pending stays empty, load_ready stays 1.
- The active value never changes mid-frame, so there is no tearing.
- Outputs are registered; an changes only on counter transitions.
- rst asserted mid-operation returns to reset values on the next edge. Any pending value is discarded.

Optional Feature:
SEVSEG_BLINK_EN: when defined, adds the blink_mask port and a free-running blink counter (period 2*BLINK_DIV, reset to 0, starts in the visible phase). During the hidden half-period, digits with blink_mask[idx]=1 are blanked (an=4'b1111 for their slot). When undefined, there is no port and no counter, and behaviour is identical to blink_mask=0.

Test Plan:
- Reset / idle (REFRESH_DIV=8, DEAD_CYCLES=2): release rst -> an=1111 for cycles 0-1; an=1110 for cycles 2-7; then slot 1 gives 1111 x2 then 1101 x6; frame_tick pulses at cycle 32.
- Load 16'h1234 mid-frame -> load_ready low the next cycle; digit_code stays 0 until the frame boundary; next frame shows 4,3,2,1 on slots 0-3; load_ready returns high.
- Load on the boundary cycle -> value is active for the immediately following frame; load_ready never drops.
- lz_en=1, value 16'h0007 -> only slot 0 lights (an=1110); slots 1-3 stay 1111. Value 16'h0000 -> slot 0 shows 0. lz_en=0 -> all four slots light.
- digit_en=4'b0101 with value 16'h9999 -> slots 1 and 3 stay dark; slots 0 and 2 light with digit_code=9.
- Assert rst during slot 2 with pending full -> outputs return to reset values; load_ready=1; the pending value never appears.
